// File: rtl/bp_fe_queue_pkg.sv
// Shared helpers for the FE->BE rollback queue: width derivations and
// wrap-bit pointer comparison.
package bp_fe_queue_pkg;

    function automatic int ptr_width(input int els);
        return $clog2(els) + 1;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Full when the index bits match and the wrap bits differ.
    function automatic logic ptr_full(input logic [31:0] a, input logic [31:0] b,
                                      input int idx_w);
        return (a[idx_w] != b[idx_w])
            && (((a ^ b) & ((32'd1 << idx_w) - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/bp_fe_queue_ptr.sv
// Wrap-bit queue pointer: each cycle either loads a target pointer or
// advances by 0..deq_width_p. The next value is exported for chaining.
module bp_fe_queue_ptr
    import bp_fe_queue_pkg::*;
#(
    parameter int els_p       = 16,
    parameter int deq_width_p = 2,
    localparam int idx_width_lp = $clog2(els_p),
    localparam int ptr_width_lp = ptr_width(els_p),
    localparam int add_width_lp = cnt_width(deq_width_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    load_v_i,
    input  logic [ptr_width_lp-1:0] load_ptr_i,
    input  logic [add_width_lp-1:0] add_i,
    output logic [ptr_width_lp-1:0] ptr_o,
    output logic [ptr_width_lp-1:0] ptr_n_o
);

    typedef struct packed {
        logic                    wrap;
        logic [idx_width_lp-1:0] idx;
    } bp_fe_queue_ptr_s;

    bp_fe_queue_ptr_s ptr_q, ptr_d;

    // Plain modular add carries naturally from idx into the wrap bit.
    always_comb begin
        ptr_d = bp_fe_queue_ptr_s'(ptr_q + ptr_width_lp'(add_i));
        if (load_v_i) ptr_d = bp_fe_queue_ptr_s'(load_ptr_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

    assign ptr_o   = ptr_q;
    assign ptr_n_o = ptr_d;

endmodule

// File: rtl/bsg_mem_1r1w.sv
// One-write one-read register-file memory, asynchronous read, no reset.
module bsg_mem_1r1w #(
    parameter int width_p = 64,
    parameter int els_p   = 16,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     w_clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    always_ff @(posedge w_clk_i) begin
        if (w_v_i) mem_q[w_addr_i] <= w_data_i;
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_fe_queue_rolly_multi.sv
// FE->BE fetch queue with write / speculative-read / commit pointers and
// multi-entry commit. BP_FE_QUEUE_BYPASS_EN enables empty-queue bypass.
module bp_fe_queue_rolly_multi
    import bp_fe_queue_pkg::*;
#(
    parameter int width_p     = 64,
    parameter int els_p       = 16,
    parameter int deq_width_p = 2,
    localparam int idx_width_lp     = $clog2(els_p),
    localparam int ptr_width_lp     = ptr_width(els_p),
    localparam int cnt_width_lp     = cnt_width(els_p),
    localparam int deq_cnt_width_lp = cnt_width(deq_width_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [width_p-1:0]          data_i,
    input  logic                        v_i,
    output logic                        ready_o,
    output logic [width_p-1:0]          data_o,
    output logic                        v_o,
    input  logic                        yumi_i,
    input  logic                        deq_v_i,
    input  logic [deq_cnt_width_lp-1:0] deq_cnt_i,
    input  logic                        roll_v_i,
    input  logic                        clr_v_i,
    output logic [cnt_width_lp-1:0]     count_o,
    output logic [cnt_width_lp-1:0]     spec_count_o
);

    logic [ptr_width_lp-1:0] wptr, rptr, cptr, wptr_n, rptr_n, cptr_n;
    logic [width_p-1:0]      mem_data;
    logic                    enq, yumi_v;

    assign enq    = v_i & ready_o;
    assign yumi_v = yumi_i & v_o;

    // Chain order: commit first, then read (may rewind to new commit),
    // then write (may truncate to new read).
    bp_fe_queue_ptr #(.els_p(els_p), .deq_width_p(deq_width_p)) cptr_u (
        .clk_i(clk_i), .reset_i(reset_i),
        .load_v_i(1'b0), .load_ptr_i('0),
        .add_i(deq_v_i ? deq_cnt_i : '0),
        .ptr_o(cptr), .ptr_n_o(cptr_n)
    );

    bp_fe_queue_ptr #(.els_p(els_p), .deq_width_p(deq_width_p)) rptr_u (
        .clk_i(clk_i), .reset_i(reset_i),
        .load_v_i(roll_v_i), .load_ptr_i(cptr_n),
        .add_i(deq_cnt_width_lp'(yumi_v)),
        .ptr_o(rptr), .ptr_n_o(rptr_n)
    );

    bp_fe_queue_ptr #(.els_p(els_p), .deq_width_p(deq_width_p)) wptr_u (
        .clk_i(clk_i), .reset_i(reset_i),
        .load_v_i(clr_v_i), .load_ptr_i(rptr_n),
        .add_i(deq_cnt_width_lp'(enq)),
        .ptr_o(wptr), .ptr_n_o(wptr_n)
    );

    bsg_mem_1r1w #(.width_p(width_p), .els_p(els_p)) mem_u (
        .w_clk_i  (clk_i),
        .w_v_i    (enq & ~clr_v_i),
        .w_addr_i (wptr[idx_width_lp-1:0]),
        .w_data_i (data_i),
        .r_addr_i (rptr[idx_width_lp-1:0]),
        .r_data_o (mem_data)
    );

    assign ready_o      = ~ptr_full(32'(wptr), 32'(cptr), idx_width_lp);
    assign count_o      = cnt_width_lp'(wptr - cptr);
    assign spec_count_o = cnt_width_lp'(rptr - cptr);

`ifdef BP_FE_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass = (rptr == wptr) & ~roll_v_i & ~clr_v_i;
    assign v_o    = bypass ? enq : (rptr != wptr);
    assign data_o = bypass ? data_i : mem_data;
`else
    assign v_o    = (rptr != wptr);
    assign data_o = mem_data;
`endif

    logic [cnt_width_lp:0] deq_limit;
    assign deq_limit = {1'b0, spec_count_o} + (cnt_width_lp+1)'(yumi_v & ~roll_v_i);

    a_enq_ready: assert property (@(posedge clk_i) disable iff (reset_i) !(v_i && !ready_o));
    a_yumi_v:    assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));
    a_deq_cnt:   assert property (@(posedge clk_i) disable iff (reset_i)
                     deq_v_i |-> (deq_cnt_i != '0) && ((cnt_width_lp+1)'(deq_cnt_i) <= deq_limit));
    a_occupancy: assert property (@(posedge clk_i) disable iff (reset_i)
                     (wptr_n - cptr_n) <= ptr_width_lp'(els_p));

endmodule

// File: tb/tb_bp_fe_queue_rolly_multi.sv
// Bench for bp_fe_queue_rolly_multi: directed scenarios then random legal
// traffic, all checked against a list-plus-read-count queue model.
module tb_bp_fe_queue_rolly_multi;

    localparam int W   = 16;
    localparam int ELS = 8;
`ifdef BP_FE_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_i;
    logic [W-1:0] data_i, data_o;
    logic         v_i, ready_o, v_o, yumi_i, deq_v_i, roll_v_i, clr_v_i;
    logic [1:0]   deq_cnt_i;
    logic [3:0]   count_o, spec_count_o;

    always #5 clk = ~clk;

    bp_fe_queue_rolly_multi #(.width_p(W), .els_p(ELS), .deq_width_p(2)) dut (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i),
        .ready_o(ready_o), .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i),
        .deq_v_i(deq_v_i), .deq_cnt_i(deq_cnt_i), .roll_v_i(roll_v_i),
        .clr_v_i(clr_v_i), .count_o(count_o), .spec_count_o(spec_count_o)
    );

    // Model: mq holds entries from the commit point onward; mr of them read.
    logic [W-1:0] mq[$];
    int           mr;
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_vo(input logic v, input logic roll, input logic clr);
        return (mr < mq.size())
            || (BYP && mr == mq.size() && v && mq.size() != ELS && !roll && !clr);
    endfunction

    task automatic idle();
        v_i = 0; data_i = '0; yumi_i = 0; deq_v_i = 0; deq_cnt_i = '0;
        roll_v_i = 0; clr_v_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset_i = 1;
        @(posedge clk);
        #1 reset_i = 0;
        mq.delete();
        mr = 0;
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_v_o", 32'(v_o), 0);
        chk("rst_count", 32'(count_o), 0);
        chk("rst_spec", 32'(spec_count_o), 0);
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic y,
                        input int k, input logic roll, input logic clr);
        logic vo;
        int   nr;
        @(negedge clk);
        v_i = v; data_i = d; yumi_i = y; deq_v_i = (k > 0); deq_cnt_i = 2'(k);
        roll_v_i = roll; clr_v_i = clr;
        #1;
        vo = m_vo(v, roll, clr);
        chk("ready", 32'(ready_o), 32'(mq.size() != ELS));
        chk("v_o", 32'(v_o), 32'(vo));
        if (vo) chk("data", 32'(data_o), 32'((mr < mq.size()) ? mq[mr] : d));
        chk("count", 32'(count_o), 32'(mq.size()));
        chk("spec", 32'(spec_count_o), 32'(mr));
        @(posedge clk);
        nr = roll ? 0 : mr + int'(y & vo) - k;
        for (int i = 0; i < k; i++) void'(mq.pop_front());
        if (clr) begin
            while (mq.size() > nr) void'(mq.pop_back());
        end else if (v) begin
            mq.push_back(d);
        end
        mr = nr;
        #1 idle();
    endtask

    initial begin
        int   k, lim;
        logic v, y, roll, clr;
        reset_i = 1;
        idle();
        mr = 0;
        do_reset();

        // Fill to capacity, then reset discards everything.
        for (int i = 0; i < 8; i++) step(1, W'(16'h10 + i), 0, 0, 0, 0);
        chk("full_ready", 32'(ready_o), 0);
        chk("full_count", 32'(count_o), 8);
        do_reset();

        // Read three, roll back to the commit point.
        for (int i = 0; i < 4; i++) step(1, W'(16'h10 + i), 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0, 0);
        step(0, '0, 0, 0, 1, 0);
        chk("roll_data", 32'(data_o), 32'h10);
        chk("roll_spec", 32'(spec_count_o), 0);
        chk("roll_count", 32'(count_o), 4);
        do_reset();

        // Commit frees space next cycle; refill wraps the index.
        for (int i = 0; i < 8; i++) step(1, W'(16'h30 + i), 0, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        step(0, '0, 0, 2, 0, 0);
        chk("deq_ready", 32'(ready_o), 1);
        chk("deq_count", 32'(count_o), 6);
        step(1, 16'h38, 0, 0, 0, 0);
        step(1, 16'h39, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, '0, 0, 2, 0, 0);
        chk("wrap_count", 32'(count_o), 0);
        do_reset();

        // Clear drops unread entries and the same-cycle enqueue.
        for (int i = 0; i < 5; i++) step(1, W'(16'h40 + i), 0, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        step(1, 16'hEE, 0, 0, 0, 1);
        chk("clr_count", 32'(count_o), 2);
        chk("clr_v_o", 32'(v_o), 0);
        step(0, '0, 0, 0, 1, 0);
        chk("clr_roll_data", 32'(data_o), 32'h40);
        do_reset();

        // yumi + roll + commit in one cycle.
        for (int i = 0; i < 3; i++) step(1, W'(16'h50 + i), 0, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        step(0, '0, 1, 1, 1, 0);
        chk("yrd_spec", 32'(spec_count_o), 0);
        chk("yrd_count", 32'(count_o), 2);
        chk("yrd_data", 32'(data_o), 32'h51);
        do_reset();

`ifdef BP_FE_QUEUE_BYPASS_EN
        // Empty-queue bypass: same-cycle visibility, entry still written.
        @(negedge clk);
        v_i = 1; data_i = 16'hAB; yumi_i = 1;
        #1;
        chk("byp_v_o", 32'(v_o), 1);
        chk("byp_data", 32'(data_o), 32'hAB);
        @(posedge clk);
        mq.push_back(16'hAB);
        mr = 1;
        #1 idle();
        chk("byp_v_next", 32'(v_o), 0);
        chk("byp_spec", 32'(spec_count_o), 1);
        chk("byp_count", 32'(count_o), 1);
        do_reset();
`endif

        // Random legal traffic with occasional mid-run reset.
        for (int c = 0; c < 1500; c++) begin
            if (c % 500 == 499) do_reset();
            v    = ($urandom_range(0, 2) != 0) && (mq.size() != ELS);
            roll = ($urandom_range(0, 15) == 0);
            clr  = ($urandom_range(0, 19) == 0);
            y    = m_vo(v, roll, clr) && ($urandom_range(0, 1) == 1);
            lim  = mr + int'(y && !roll);
            if (lim > 2) lim = 2;
            k    = $urandom_range(0, lim);
            step(v, W'($urandom), y, k, roll, clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bp_fe_queue_rolly_multi.md
Name: bp_fe_queue_rolly_multi

Overview:
Parametrised successor to the single-entry-commit FE→BE rollback queue. It sits between bp_fe_top and bp_be_top and buffers fetch packets. It keeps three pointers: write, speculative read and commit. The BE can commit up to deq_width_p entries per cycle, roll speculative reads back to the commit point, or clear unread entries after a redirect.

Parameters:
width_p, 64, entry width in bits (fe_queue_width_lp at integration)
els_p, 16, queue depth; power of two, >= 2
deq_width_p, 2, maximum entries committed in one cycle; 1 <= deq_width_p <= els_p
ptr_width_lp, $clog2(els_p)+1, pointer width including wrap bit (derived)
cnt_width_lp, $clog2(els_p+1), occupancy width (derived)
deq_cnt_width_lp, $clog2(deq_width_p+1), commit-count width (derived)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
data_i  in  width_p  enqueue data
v_i  in  1  enqueue valid; asserted only when ready_o=1 (ready-then-valid)
ready_o  out  1  space available
data_o  out  width_p  entry at speculative read pointer
v_o  out  1  data_o valid
yumi_i  in  1  consumer took data_o; only legal when v_o=1
deq_v_i  in  1  commit request
deq_cnt_i  in  deq_cnt_width_lp  entries to commit; 1..deq_width_p
roll_v_i  in  1  rewind speculative read pointer to the commit pointer
clr_v_i  in  1  drop all unread entries
count_o  out  cnt_width_lp  wptr-cptr (total held, committed-space view)
spec_count_o  out  cnt_width_lp  rptr-cptr (read but uncommitted)

Behaviour:
- Reset: wptr=rptr=cptr=0; ready_o=1, v_o=0, count_o=0, spec_count_o=0. Reset mid-operation discards all entries. Memory contents are not cleared.
- Pointers carry a wrap bit. The index is the low $clog2(els_p) bits. Full when index equal and wrap differs. All arithmetic is mod 2^ptr_width_lp.
- ready_o = (wptr-cptr) != els_p. Space is reclaimed only by commit, never by yumi.
- v_o = (rptr != wptr). data_o = mem[rptr index], read asynchronously from registered state.
- Next-state order each cycle, computed combinationally:
  - cptr_n = cptr + (deq_v_i ? deq_cnt_i : 0)
  - rptr_n = roll_v_i ? cptr_n : rptr + (yumi_i & v_o)
  - wptr_n = clr_v_i ? rptr_n : wptr + (v_i & ready_o)
- Simultaneous events:
  - roll beats yumi; the yumi is discarded.
  - clr beats enqueue; data_i is not retained.
  - roll+clr together empty the queue to cptr_n.
  - deq is always applied first.
- Enqueue-to-v_o latency is 1 cycle.
- A commit becomes visible in ready_o the next cycle.
- Illegal conditions (sim assertions, ignored in synthesis):
  - v_i & ~ready_o
  - yumi_i & ~v_o
  - deq_cnt_i > spec_count_o + (yumi_i & v_o & ~roll_v_i)
  - deq_cnt_i == 0 while deq_v_i=1
- Commits may include the entry yumi'd in the same cycle.

Optional Feature:
Macro BP_FE_QUEUE_BYPASS_EN.
- Defined: when rptr==wptr and roll_v_i=clr_v_i=0, v_o=v_i and data_o=data_i in the same cycle. The entry is still written, so yumi in that cycle advances both wptr and rptr. Latency is 0.
- Undefined: no combinational path from data_i/v_i to outputs; latency is 1.

Decomposition:
- Shared package bp_fe_queue_pkg: typedef bp_fe_queue_ptr_s {wrap, idx}; function for full/empty compare; localparam derivations for ptr/cnt widths.
- Sub-module bp_fe_queue_ptr: wrap-bit pointer register with load (roll/clr target) and add (0..deq_width_p) inputs. It is instantiated three times.
- Storage uses existing bsg_mem_1r1w (width_p x els_p, async read).

Test Plan:
- els_p=8, deq_width_p=2, bypass off. Enqueue 8 words 0x10..0x17 → ready_o=0 after the 8th and count_o=8. v_i held → assertion fires.
- Enqueue 4, yumi 3 (read 0x10..0x12), roll_v_i → next data_o=0x10, spec_count_o=0, count_o=4.
- Enqueue 8, yumi 2, deq_v_i with deq_cnt_i=2 → ready_o returns next cycle, count_o=6. Enqueue 2 more → wrap-around data read correctly in order.
- Enqueue 5, yumi 2, clr_v_i together with v_i → count_o=2, v_o=0, the clr-cycle data is not retained. A following roll → data_o is the first entry again.
- Same-cycle yumi+roll+deq_cnt=1 with 3 entries read → cptr+1, rptr=cptr_n, spec_count_o=0, count_o reduced by 1.
- Bypass on, empty queue: v_i=1 with data 0xAB and yumi_i=1 → data_o=0xAB same cycle, v_o=0 next cycle, spec_count_o=1.
